vlan_stack_resolver: RTL and testbench
======================================

# vlan_stack_resolver

Parametrised L2 tag walker that resolves zero to MAX_TAGS stacked VLAN tags (802.1Q, 802.1ad, optional 0x9100) and the final EtherType. Sits between the Ethernet header parser and the L3 dispatch stage. It accepts one captured header window per valid/ready handshake and walks the tag stack one tag per cycle. It presents per-tag TCI fields, tag count, L2 header length and an overflow error on a valid/ready output.

## Interface
Parameters:
- MAX_TAGS, 2: maximum tags decoded; legal range 1..4.
- ACCEPT_8021AD, 1: treat 0x88A8 as a tag TPID.
- ACCEPT_9100, 0: treat 0x9100 as a tag TPID.
- HDR_BYTES, derived localparam = 14 + 4*MAX_TAGS.
- LEN_W, derived localparam = $clog2(HDR_BYTES+1).

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset, synchronous, active-high.
- hdr_valid, in, 1: header window valid.
- hdr_ready, out, 1: block can accept a header.
- header_bytes, in, HDR_BYTES*8: byte n at [n*8 +: 8]; byte 0 is the first byte on the wire.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- tag_count, out, 3: number of tags decoded, 0..MAX_TAGS.
- tag_vid, out, MAX_TAGS*12: slot k at [k*12 +: 12]; slot 0 is outermost.
- tag_pcp, out, MAX_TAGS*3: slot k PCP.
- tag_dei, out, MAX_TAGS: slot k DEI.
- tag_is_ad, out, MAX_TAGS: slot k TPID was 0x88A8.
- resolved_ethertype, out, 16: EtherType following the last tag.
- l2_header_len, out, LEN_W: bytes from DA through the resolved EtherType.
- tag_overflow, out, 1: a further tag TPID was found after MAX_TAGS tags.

## Operation
- Word at offset o is {byte o, byte o+1}, big-endian.
- TCI at offset o+2 splits as follows:
  - PCP = byte(o+2)[7:5]
  - DEI = byte(o+2)[4]
  - VID = {byte(o+2)[3:0], byte(o+3)}
- A word is a TPID when any of these holds:
  - it equals 0x8100;
  - it equals 0x88A8 and ACCEPT_8021AD=1;
  - it equals 0x9100 and ACCEPT_9100=1.
- FSM states:
  - IDLE: hdr_ready=1. On hdr_valid, latch header_bytes, set offset=12 and cnt=0, clear all tag slots and tag_overflow, then go to WALK.
  - WALK: examine the word at offset, one examination per cycle.
    - TPID and cnt<MAX_TAGS: write slot cnt, cnt+=1, offset+=4, stay in WALK.
    - TPID and cnt==MAX_TAGS: resolved_ethertype=word, tag_overflow=1, l2_header_len=offset+2, go to DONE.
    - Otherwise: resolved_ethertype=word, l2_header_len=offset+2, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- offset never exceeds 12+4*MAX_TAGS, so every read stays inside HDR_BYTES.
- Untagged frame: tag_count=0, l2_header_len=14, resolved_ethertype=bytes 12–13.
- Values below 0x0600 (length field) are not special-cased; they are passed through as resolved_ethertype.

## Timing
- Accept edge: hdr_valid && hdr_ready.
- Latency: with n tags decoded, out_valid rises n+2 cycles after the accept edge. The accept cycle plus n+1 WALK cycles.
- Overflow case: n = MAX_TAGS, so latency is MAX_TAGS+2.
- hdr_ready is 1 only in IDLE and 0 while rst is high. No new header is accepted in the cycle a result is consumed.
- All outputs are registered. They are stable while out_valid && !out_ready.
- After a handshake the result outputs hold their values until the next accept. out_valid deasserts on the cycle after the handshake.
- Reset (any state, including mid-WALK or DONE) on the next edge:
  - FSM goes to IDLE and any in-flight header is dropped.
  - out_valid=0 and tag_count=0.
  - tag_vid, tag_pcp, tag_dei and tag_is_ad are all 0.
  - resolved_ethertype=0, l2_header_len=0, tag_overflow=0.

## Structure
- eth_parser_pkg holds:
  - ethertype_t;
  - constants TPID_8021Q=16'h8100, TPID_8021AD=16'h88A8, TPID_9100=16'h9100;
  - vlan_tci_t, a packed struct {pcp[2:0], dei, vid[11:0]}.
- Sub-module vlan_tag_decode, purely combinational:
  - inputs: 16-bit word, 16-bit TCI, the ACCEPT_* parameters;
  - outputs: is_tpid, is_ad, vlan_tci_t.
  - Instantiated once and fed by an offset-indexed mux.

## Test plan
- Untagged: bytes 12–13 = 0x0800 → after 2 cycles: tag_count=0, ethertype=0x0800, len=14, overflow=0.
- Single 802.1Q: 0x8100, TCI 0xA123, then 0x86DD → after 3 cycles: count=1, slot0 pcp=5, dei=0, vid=0x123, is_ad=0, ethertype=0x86DD, len=18.
- QinQ: 0x88A8/TCI 0x0064, 0x8100/TCI 0x20C8, 0x0800 → after 4 cycles: count=2, vid0=0x064, is_ad0=1, vid1=0x0C8, pcp1=1, ethertype=0x0800, len=22.
- Overflow, MAX_TAGS=2: three 0x8100 tags → count=2, overflow=1, ethertype=0x8100, len=22.
- Backpressure: hold out_ready=0 for 5 cycles → outputs stable and hdr_ready=0 throughout; after the handshake, hdr_ready=1 on the next cycle.
- Reset mid-WALK on a QinQ frame: assert rst for 1 cycle → next cycle all outputs 0 and hdr_ready=1. A following 0x0800 frame then resolves normally.

Source files
------------

// File: rtl/eth_parser_pkg.sv
// Shared L2 parser types: EtherType, VLAN TPID constants and the TCI layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eth_parser_pkg;

    typedef logic [15:0] ethertype_t;

    localparam ethertype_t TPID_8021Q  = 16'h8100;
    localparam ethertype_t TPID_8021AD = 16'h88A8;
    localparam ethertype_t TPID_9100   = 16'h9100;

    // Field order matches the wire layout of the 16-bit TCI, so a plain cast splits it.
    typedef struct packed {
        logic [2:0]  pcp;
        logic        dei;
        logic [11:0] vid;
    } vlan_tci_t;

endpackage

// File: rtl/vlan_tag_decode.sv
// Classifies one candidate TPID word and splits the TCI that follows it.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module vlan_tag_decode
    import eth_parser_pkg::*;
#(
    parameter bit ACCEPT_8021AD = 1'b1,
    parameter bit ACCEPT_9100   = 1'b0
) (
    input  ethertype_t  word,
    input  logic [15:0] tci_raw,
    output logic        is_tpid,
    output logic        is_ad,
    output vlan_tci_t   tci
);

    // TPID match against the enabled tag types; 0x8100 is always a tag.
    always_comb begin
        is_ad   = ACCEPT_8021AD && (word == TPID_8021AD);
        is_tpid = (word == TPID_8021Q) || is_ad || (ACCEPT_9100 && (word == TPID_9100));
        tci     = vlan_tci_t'(tci_raw);
    end

endmodule

// File: rtl/vlan_stack_resolver.sv
// Walks up to MAX_TAGS stacked VLAN tags in a captured header and resolves the final EtherType.
// Latency: n+2 cycles from accept to out_valid with n tags decoded (one WALK cycle per tag plus one).
// Backpressure: one header in flight; hdr_ready only in IDLE, result held in DONE until out_ready.
module vlan_stack_resolver
    import eth_parser_pkg::*;
#(
    parameter int  MAX_TAGS      = 2,
    parameter bit  ACCEPT_8021AD = 1'b1,
    parameter bit  ACCEPT_9100   = 1'b0,
    localparam int HDR_BYTES     = 14 + 4*MAX_TAGS,
    localparam int LEN_W         = $clog2(HDR_BYTES+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hdr_valid,
    output logic                    hdr_ready,
    input  logic [HDR_BYTES*8-1:0]  header_bytes,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              tag_count,
    output logic [MAX_TAGS*12-1:0]  tag_vid,
    output logic [MAX_TAGS*3-1:0]   tag_pcp,
    output logic [MAX_TAGS-1:0]     tag_dei,
    output logic [MAX_TAGS-1:0]     tag_is_ad,
    output logic [15:0]             resolved_ethertype,
    output logic [LEN_W-1:0]        l2_header_len,
    output logic                    tag_overflow
);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    // Bytes 12.. onward; DA/SA never influence the walk so they are not stored.
    localparam int TAIL_BYTES = HDR_BYTES - 12;

    state_t                  state;
    logic [TAIL_BYTES*8-1:0] tail_q;
    logic [LEN_W-1:0]        offset;
    ethertype_t              word;
    logic [15:0]             tci_raw;
    logic                    is_tpid;
    logic                    is_ad;
    vlan_tci_t               tci;
    logic                    unused_hdr;

    assign unused_hdr = ^header_bytes[12*8-1:0];
    assign hdr_ready  = (state == IDLE) && !rst;

    // Offset-indexed mux; the final position only has an EtherType, no TCI behind it.
    always_comb begin
        word    = '0;
        tci_raw = '0;
        for (int k = 0; k < MAX_TAGS; k++) begin
            if (offset == LEN_W'(12 + 4*k)) begin
                word    = {tail_q[(4*k)*8 +: 8],   tail_q[(4*k+1)*8 +: 8]};
                tci_raw = {tail_q[(4*k+2)*8 +: 8], tail_q[(4*k+3)*8 +: 8]};
            end
        end
        if (offset == LEN_W'(12 + 4*MAX_TAGS)) begin
            word = {tail_q[(4*MAX_TAGS)*8 +: 8], tail_q[(4*MAX_TAGS+1)*8 +: 8]};
        end
    end

    vlan_tag_decode #(
        .ACCEPT_8021AD (ACCEPT_8021AD),
        .ACCEPT_9100   (ACCEPT_9100)
    ) u_decode (
        .word    (word),
        .tci_raw (tci_raw),
        .is_tpid (is_tpid),
        .is_ad   (is_ad),
        .tci     (tci)
    );

    // Walker FSM: capture, one tag examination per cycle, then hold result until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            offset             <= '0;
            out_valid          <= 1'b0;
            tag_count          <= '0;
            tag_vid            <= '0;
            tag_pcp            <= '0;
            tag_dei            <= '0;
            tag_is_ad          <= '0;
            resolved_ethertype <= '0;
            l2_header_len      <= '0;
            tag_overflow       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hdr_valid) begin
                        tail_q       <= header_bytes[HDR_BYTES*8-1:12*8];
                        offset       <= LEN_W'(12);
                        tag_count    <= '0;
                        tag_vid      <= '0;
                        tag_pcp      <= '0;
                        tag_dei      <= '0;
                        tag_is_ad    <= '0;
                        tag_overflow <= 1'b0;
                        state        <= WALK;
                    end
                end
                WALK: begin
                    if (is_tpid && (tag_count < 3'(MAX_TAGS))) begin
                        for (int k = 0; k < MAX_TAGS; k++) begin
                            if (tag_count == 3'(k)) begin
                                tag_vid[k*12 +: 12] <= tci.vid;
                                tag_pcp[k*3 +: 3]   <= tci.pcp;
                                tag_dei[k]          <= tci.dei;
                                tag_is_ad[k]        <= is_ad;
                            end
                        end
                        tag_count <= tag_count + 3'd1;
                        offset    <= offset + LEN_W'(4);
                    end else begin
                        // A TPID here means the stack is deeper than we decode.
                        resolved_ethertype <= word;
                        tag_overflow       <= is_tpid;
                        l2_header_len      <= offset + LEN_W'(2);
                        out_valid          <= 1'b1;
                        state              <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vlan_stack_resolver.sv
// Self-checking bench for vlan_stack_resolver: directed scenarios plus randomized frames vs a reference model.
// Latency: checks out_valid arrives n+2 cycles after accept.
// Backpressure: holds out_ready low and checks outputs stay stable.
module tb_vlan_stack_resolver;

    localparam int MAX_TAGS  = 2;
    localparam int HDR_BYTES = 14 + 4*MAX_TAGS;
    localparam int LEN_W     = $clog2(HDR_BYTES+1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   hdr_valid;
    logic                   hdr_ready;
    logic [HDR_BYTES*8-1:0] header_bytes;
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0]             tag_count;
    logic [MAX_TAGS*12-1:0] tag_vid;
    logic [MAX_TAGS*3-1:0]  tag_pcp;
    logic [MAX_TAGS-1:0]    tag_dei;
    logic [MAX_TAGS-1:0]    tag_is_ad;
    logic [15:0]            resolved_ethertype;
    logic [LEN_W-1:0]       l2_header_len;
    logic                   tag_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    byte unsigned frame [HDR_BYTES];

    // Reference model results
    int                     exp_count;
    int                     exp_etype;
    int                     exp_len;
    int                     exp_ovf;
    logic [MAX_TAGS*12-1:0] exp_vid;
    logic [MAX_TAGS*3-1:0]  exp_pcp;
    logic [MAX_TAGS-1:0]    exp_dei;
    logic [MAX_TAGS-1:0]    exp_ad;

    vlan_stack_resolver #(.MAX_TAGS(MAX_TAGS)) dut (
        .clk                (clk),
        .rst                (rst),
        .hdr_valid          (hdr_valid),
        .hdr_ready          (hdr_ready),
        .header_bytes       (header_bytes),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .tag_count          (tag_count),
        .tag_vid            (tag_vid),
        .tag_pcp            (tag_pcp),
        .tag_dei            (tag_dei),
        .tag_is_ad          (tag_is_ad),
        .resolved_ethertype (resolved_ethertype),
        .l2_header_len      (l2_header_len),
        .tag_overflow       (tag_overflow)
    );

    always #5 clk = ~clk;

    function automatic int word_at(int off);
        return int'(frame[off]) * 256 + int'(frame[off+1]);
    endfunction

    // Default parameters: 0x8100 and 0x88A8 are tags, 0x9100 is not.
    function automatic bit is_tag(int w);
        return (w == 32'h8100) || (w == 32'h88A8);
    endfunction

    task automatic model();
        int off;
        int w;
        int t;
        bit done;
        off = 12; done = 0;
        exp_count = 0; exp_ovf = 0;
        exp_vid = '0; exp_pcp = '0; exp_dei = '0; exp_ad = '0;
        while (!done) begin
            w = word_at(off);
            if (is_tag(w) && exp_count < MAX_TAGS) begin
                t = word_at(off + 2);
                exp_pcp[exp_count*3 +: 3]   = 3'(t >> 13);
                exp_dei[exp_count]          = 1'(t >> 12);
                exp_vid[exp_count*12 +: 12] = 12'(t);
                exp_ad[exp_count]           = (w == 32'h88A8);
                exp_count++;
                off += 4;
            end else begin
                exp_ovf   = is_tag(w) ? 1 : 0;
                exp_etype = w;
                exp_len   = off + 2;
                done      = 1;
            end
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < HDR_BYTES; i++) frame[i] = 8'h00;
    endtask

    task automatic set_word(int off, int w);
        frame[off]   = 8'(w >> 8);
        frame[off+1] = 8'(w);
    endtask

    // Drives one header, returns cycles from the accept edge to out_valid (-1 on timeout).
    task automatic run_frame(output int lat);
        for (int i = 0; i < HDR_BYTES; i++) header_bytes[i*8 +: 8] = frame[i];
        @(negedge clk);
        hdr_valid = 1'b1;
        @(posedge clk);
        #1 hdr_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; hdr_valid = 1'b0; out_ready = 1'b0; header_bytes = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (hdr_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hdr_ready_in_rst: got %b expected 0", hdr_ready);
        end
        tests_run++;
        if ({out_valid, tag_count, tag_vid, tag_pcp, tag_dei, tag_is_ad, resolved_ethertype,
             l2_header_len, tag_overflow} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: out_valid=%b count=%0d eth=%h len=%0d expected all 0",
                     out_valid, tag_count, resolved_ethertype, l2_header_len);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (hdr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_hdr_ready_after: got %b expected 1", hdr_ready);
        end
    endtask

    task automatic test_untagged();
        int lat;
        clear_frame();
        set_word(12, 16'h0800);
        run_frame(lat);
        tests_run++;
        if (lat !== 2 || tag_count !== 3'd0 || resolved_ethertype !== 16'h0800 ||
            l2_header_len !== LEN_W'(14) || tag_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL untagged: lat=%0d count=%0d eth=%h len=%0d ovf=%b expected 2/0/0800/14/0",
                     lat, tag_count, resolved_ethertype, l2_header_len, tag_overflow);
        end
        consume();
    endtask

    task automatic test_single_q();
        int lat;
        clear_frame();
        set_word(12, 16'h8100);
        set_word(14, 16'hA123);
        set_word(16, 16'h86DD);
        run_frame(lat);
        tests_run++;
        if (lat !== 3 || tag_count !== 3'd1 || resolved_ethertype !== 16'h86DD ||
            l2_header_len !== LEN_W'(18)) begin
            tests_failed++;
            $display("FAIL single_q_result: lat=%0d count=%0d eth=%h len=%0d expected 3/1/86dd/18",
                     lat, tag_count, resolved_ethertype, l2_header_len);
        end
        tests_run++;
        if (tag_pcp[2:0] !== 3'd5 || tag_dei[0] !== 1'b0 || tag_vid[11:0] !== 12'h123 ||
            tag_is_ad[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_q_slot0: pcp=%0d dei=%b vid=%h ad=%b expected 5/0/123/0",
                     tag_pcp[2:0], tag_dei[0], tag_vid[11:0], tag_is_ad[0]);
        end
        consume();
    endtask

    task automatic load_qinq();
        clear_frame();
        set_word(12, 16'h88A8);
        set_word(14, 16'h0064);
        set_word(16, 16'h8100);
        set_word(18, 16'h20C8);
        set_word(20, 16'h0800);
    endtask

    task automatic test_qinq();
        int lat;
        load_qinq();
        run_frame(lat);
        tests_run++;
        if (lat !== 4 || tag_count !== 3'd2 || resolved_ethertype !== 16'h0800 ||
            l2_header_len !== LEN_W'(22) || tag_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL qinq_result: lat=%0d count=%0d eth=%h len=%0d ovf=%b expected 4/2/0800/22/0",
                     lat, tag_count, resolved_ethertype, l2_header_len, tag_overflow);
        end
        tests_run++;
        if (tag_vid[11:0] !== 12'h064 || tag_is_ad[0] !== 1'b1 || tag_vid[23:12] !== 12'h0C8 ||
            tag_pcp[5:3] !== 3'd1 || tag_is_ad[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL qinq_slots: vid0=%h ad0=%b vid1=%h pcp1=%0d ad1=%b expected 064/1/0c8/1/0",
                     tag_vid[11:0], tag_is_ad[0], tag_vid[23:12], tag_pcp[5:3], tag_is_ad[1]);
        end
        consume();
    endtask

    task automatic test_overflow();
        int lat;
        clear_frame();
        set_word(12, 16'h8100);
        set_word(14, 16'h0001);
        set_word(16, 16'h8100);
        set_word(18, 16'h0002);
        set_word(20, 16'h8100);
        run_frame(lat);
        tests_run++;
        if (lat !== MAX_TAGS + 2 || tag_count !== 3'd2 || tag_overflow !== 1'b1 ||
            resolved_ethertype !== 16'h8100 || l2_header_len !== LEN_W'(22)) begin
            tests_failed++;
            $display("FAIL overflow: lat=%0d count=%0d ovf=%b eth=%h len=%0d expected 4/2/1/8100/22",
                     lat, tag_count, tag_overflow, resolved_ethertype, l2_header_len);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0]            snap_eth;
        logic [MAX_TAGS*12-1:0] snap_vid;
        logic [LEN_W-1:0]       snap_len;
        clear_frame();
        set_word(12, 16'h8100);
        set_word(14, 16'h3456);
        set_word(16, 16'h0806);
        run_frame(lat);
        snap_eth = resolved_ethertype; snap_vid = tag_vid; snap_len = l2_header_len;
        tests_run++;
        if (snap_eth !== 16'h0806 || snap_vid[11:0] !== 12'h456) begin
            tests_failed++;
            $display("FAIL bp_result: eth=%h vid0=%h expected 0806/456", snap_eth, snap_vid[11:0]);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || hdr_ready !== 1'b0 || resolved_ethertype !== snap_eth ||
                tag_vid !== snap_vid || l2_header_len !== snap_len) begin
                tests_failed++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b hdr_ready=%b eth=%h expected 1/0/%h",
                         c, out_valid, hdr_ready, resolved_ethertype, snap_eth);
            end
        end
        // Offer a new header in the consume cycle: it must not be taken there.
        @(negedge clk);
        out_ready = 1'b1;
        hdr_valid = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        hdr_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || hdr_ready !== 1'b1 || resolved_ethertype !== snap_eth ||
            tag_vid !== snap_vid) begin
            tests_failed++;
            $display("FAIL bp_after_handshake: out_valid=%b hdr_ready=%b eth=%h expected 0/1/%h",
                     out_valid, hdr_ready, resolved_ethertype, snap_eth);
        end
    endtask

    task automatic test_reset_mid_walk();
        int lat;
        load_qinq();
        for (int i = 0; i < HDR_BYTES; i++) header_bytes[i*8 +: 8] = frame[i];
        @(negedge clk);
        hdr_valid = 1'b1;
        @(posedge clk);
        #1 hdr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        tests_run++;
        if (hdr_ready !== 1'b1 ||
            {out_valid, tag_count, tag_vid, tag_pcp, tag_dei, tag_is_ad, resolved_ethertype,
             l2_header_len, tag_overflow} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_walk: hdr_ready=%b out_valid=%b count=%0d vid=%h eth=%h len=%0d expected 1 and all 0",
                     hdr_ready, out_valid, tag_count, tag_vid, resolved_ethertype, l2_header_len);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_drops_inflight: out_valid=%b expected 0", out_valid);
        end
        clear_frame();
        set_word(12, 16'h0800);
        run_frame(lat);
        tests_run++;
        if (lat !== 2 || tag_count !== 3'd0 || resolved_ethertype !== 16'h0800 ||
            l2_header_len !== LEN_W'(14)) begin
            tests_failed++;
            $display("FAIL post_reset_frame: lat=%0d count=%0d eth=%h len=%0d expected 2/0/0800/14",
                     lat, tag_count, resolved_ethertype, l2_header_len);
        end
        consume();
    endtask

    task automatic test_random();
        int lat;
        int ntags;
        int off;
        int pick;
        for (int f = 0; f < 60; f++) begin
            for (int i = 0; i < HDR_BYTES; i++) frame[i] = 8'($urandom);
            ntags = $urandom_range(0, MAX_TAGS + 1);
            off = 12;
            for (int t = 0; t < ntags; t++) begin
                pick = $urandom_range(0, 5);
                set_word(off, pick == 5 ? 16'h9100 : (pick >= 3 ? 16'h88A8 : 16'h8100));
                if (off + 3 < HDR_BYTES) set_word(off + 2, int'($urandom_range(0, 65535)));
                off += 4;
            end
            if (off + 1 < HDR_BYTES) begin
                pick = $urandom_range(0, 3);
                set_word(off, pick == 0 ? 16'h0800 : pick == 1 ? 16'h86DD :
                              pick == 2 ? 16'h0040 : int'($urandom_range(0, 65535)));
            end
            model();
            run_frame(lat);
            tests_run++;
            if (lat !== exp_count + 2) begin
                tests_failed++;
                $display("FAIL rand_latency frame %0d: got %0d expected %0d", f, lat, exp_count + 2);
            end
            tests_run++;
            if (tag_count !== 3'(exp_count) || resolved_ethertype !== 16'(exp_etype) ||
                l2_header_len !== LEN_W'(exp_len) || tag_overflow !== 1'(exp_ovf)) begin
                tests_failed++;
                $display("FAIL rand_result frame %0d: count=%0d eth=%h len=%0d ovf=%b expected %0d/%h/%0d/%0d",
                         f, tag_count, resolved_ethertype, l2_header_len, tag_overflow,
                         exp_count, exp_etype, exp_len, exp_ovf);
            end
            tests_run++;
            if (tag_vid !== exp_vid || tag_pcp !== exp_pcp || tag_dei !== exp_dei ||
                tag_is_ad !== exp_ad) begin
                tests_failed++;
                $display("FAIL rand_slots frame %0d: vid=%h pcp=%h dei=%b ad=%b expected %h/%h/%b/%b",
                         f, tag_vid, tag_pcp, tag_dei, tag_is_ad, exp_vid, exp_pcp, exp_dei, exp_ad);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_untagged();
        test_single_q();
        test_qinq();
        test_overflow();
        test_backpressure();
        test_reset_mid_walk();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
